// File: rtl/sum_block_accumulator_if.sv
// Valid/ready bus for the block accumulator: sample stream in, block totals out.
// master = upstream producer plus downstream consumer; slave = accumulator.
interface sum_block_accumulator_if #(
  parameter int N     = 10,
  parameter int CNT_W = 3
);
  logic [N:0]           sum_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic [N+CNT_W:0]     out_total;
  logic [CNT_W-1:0]     out_count;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output sum_in, in_valid, flush, out_ready,
    input  in_ready, out_total, out_count, out_valid
  );

  modport slave (
    input  sum_in, in_valid, flush, out_ready,
    output in_ready, out_total, out_count, out_valid
  );
endinterface

// File: rtl/sum_block_accumulator.sv
// Accumulates BLOCK_LEN adder sums per block and emits each total with its sample
// count; flush closes a partial block early. One HOLD cycle (minimum) per block.
module sum_block_accumulator #(
  parameter int N         = 10,
  parameter int BLOCK_LEN = 4,
  parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sum_block_accumulator_if.slave bus
);
  localparam int TW = N + 1 + CNT_W;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, emit;

  assign accept = bus.in_valid && (state == ACCUM);

  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    if (accept) begin
      acc_nxt = acc + {{CNT_W{1'b0}}, bus.sum_in};
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Block close: full count, or flush with at least one sample (incl. this beat).
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if ((accept && (cnt_nxt == CNT_W'(BLOCK_LEN))) ||
                 (bus.flush && (cnt_nxt != '0)))
               state_nxt = HOLD;
      HOLD:  if (bus.out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == ACCUM);
    emit         = (state == ACCUM) && (state_nxt == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      cnt           <= '0;
      bus.out_total <= '0;
      bus.out_count <= '0;
      bus.out_valid <= 1'b0;
    end else if (emit) begin
      bus.out_total <= acc_nxt;
      bus.out_count <= cnt_nxt;
      bus.out_valid <= 1'b1;
      acc           <= '0;
      cnt           <= '0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      if (state == HOLD && bus.out_ready) bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sum_block_accumulator.sv
// Directed bench: stimulus pushes expected block results, a monitor pops and
// compares them on every output handshake.
module tb_sum_block_accumulator;
  localparam int N = 10, BLOCK_LEN = 4, CNT_W = 3;

  typedef struct {
    logic [N+CNT_W:0] total;
    logic [CNT_W-1:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   outputs = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sum_block_accumulator_if #(.N(N), .CNT_W(CNT_W)) bus ();

  sum_block_accumulator #(.N(N), .BLOCK_LEN(BLOCK_LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int total, input int count);
    exp_t e;
    e.total = (N+CNT_W+1)'(total);
    e.count = CNT_W'(count);
    exp_q.push_back(e);
  endtask

  // Drive one beat, wait (bounded) for in_ready, return at posedge+1 after accept.
  task automatic send(input int v, input bit fl);
    int n;
    n = 0;
    bus.sum_in = (N+1)'(v); bus.in_valid = 1'b1; bus.flush = fl;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, needed 1", n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: a handshake seen at negedge completes at the following posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        outputs++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output: total=%0d count=%0d, none expected",
                   bus.out_total, bus.out_count);
        end else begin
          e = exp_q.pop_front();
          chk("out_total", int'(bus.out_total), int'(e.total));
          chk("out_count", int'(bus.out_count), int'(e.count));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sum_in = '0; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_total", int'(bus.out_total), 0);
    chk("rst_out_count", int'(bus.out_count), 0);
    chk("rst_in_ready",  int'(bus.in_ready), 1);

    // Basic block; in_ready drops for exactly the single HOLD cycle.
    push(346, 4);
    send(0, 0); send(100, 0); send(99, 0); send(147, 0);
    chk("blk_valid_lat", int'(bus.out_valid), 1);
    chk("blk_in_ready_hold", int'(bus.in_ready), 0);
    cyc(1);
    chk("blk_in_ready_back", int'(bus.in_ready), 1);
    chk("blk_valid_drop", int'(bus.out_valid), 0);

    // Maximum sums, no overflow.
    push(8184, 4);
    for (int i = 0; i < 4; i++) send(2046, 0);
    cyc(1);

    // Flush without a beat, then flush with an empty block.
    push(30, 2);
    send(10, 0); send(20, 0);
    bus.flush = 1'b1; cyc(1); bus.flush = 1'b0;
    chk("flush_valid", int'(bus.out_valid), 1);
    cyc(1);
    bus.flush = 1'b1; cyc(1); bus.flush = 1'b0;
    chk("empty_flush_valid", int'(bus.out_valid), 0);
    cyc(1);
    chk("empty_flush_valid2", int'(bus.out_valid), 0);

    // Flush on the completing beat, then on the 3rd beat.
    push(10, 4);
    send(1, 0); send(2, 0); send(3, 0); send(4, 1);
    push(6, 3);
    send(1, 0); send(2, 0); send(3, 1);
    cyc(2);
    chk("flush_outputs", outputs, 5);

    // Backpressure: in_valid held during a 5-cycle stall.
    bus.out_ready = 1'b0;
    push(4, 4);
    for (int i = 0; i < 4; i++) send(1, 0);
    bus.sum_in = 11'd500; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", int'(bus.in_ready), 0);
      chk("stall_total", int'(bus.out_total), 4);
      chk("stall_valid", int'(bus.out_valid), 1);
      cyc(1);
    end
    bus.out_ready = 1'b1;
    push(2000, 4);
    for (int i = 0; i < 4; i++) send(500, 0);
    cyc(1);

    // Reset mid-block.
    send(7, 0); send(7, 0);
    #2 rst_n = 1'b0; #1;
    chk("rst_mid_valid", int'(bus.out_valid), 0);
    chk("rst_mid_total", int'(bus.out_total), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    push(20, 4);
    for (int i = 0; i < 4; i++) send(5, 0);
    cyc(1);

    // Reset mid-HOLD; the held block is discarded, not checked.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(9, 0);
    chk("hold_total", int'(bus.out_total), 36);
    #2 rst_n = 1'b0; #1;
    chk("rst_hold_valid", int'(bus.out_valid), 0);
    chk("rst_hold_total", int'(bus.out_total), 0);
    chk("rst_hold_count", int'(bus.out_count), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready2", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    push(20, 4);
    for (int i = 0; i < 4; i++) send(5, 0);
    cyc(3);

    chk("queue_drained", exp_q.size(), 0);
    chk("total_outputs", outputs, 9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
